// File: rtl/wb_trace_uart.sv
// wb_trace_uart: captures changes of the integer writeback value into a FIFO
// and streams each entry out of a UART TX pin (8N1) as an ASCII hex line.
// Optional build macro WB_TRACE_FLAGS_EN: entries also carry fp_flags, and each
// line gets a space plus two hex digits of {3'b0, fp_flags} before CR/LF.
module wb_trace_uart #(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [31:0]                   wb_data,
    input  logic [4:0]                    fp_flags,
    input  logic                          capture_en,
    output logic                          uart_tx,
    output logic                          busy,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    overflow_cnt
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int CW  = $clog2(DIV);

`ifdef WB_TRACE_FLAGS_EN
    localparam int EW  = 37;
    localparam int NCH = 13;
    logic [EW-1:0] cap_word;
    logic [4:0]    flags_q;
    assign cap_word = {fp_flags, wb_data};
`else
    localparam int EW  = 32;
    localparam int NCH = 10;
    logic [EW-1:0] cap_word;
    logic          unused_flags;
    assign cap_word     = wb_data;
    assign unused_flags = ^fp_flags;
`endif

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [EW-1:0] last_cap;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level_nxt;
    logic          push_req, push_ok, pop;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [3:0]    char_idx;
    logic [7:0]    tx_char, next_char;
    logic [31:0]   data_sh;
    logic          bit_end;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
    endfunction

    // Full is the registered flag, so a push seen while full is dropped even
    // if the engine pops in the same cycle.
    assign push_req = capture_en && (cap_word != last_cap);
    assign push_ok  = push_req && !fifo_full;
    assign pop      = (state == S_IDLE) && (fifo_level != '0);
    assign bit_end  = (cnt == CW'(DIV - 1));

    // Occupancy after this edge
    always_comb begin
        level_nxt = fifo_level;
        if (push_ok && !pop)
            level_nxt = fifo_level + LW'(1);
        else if (!push_ok && pop)
            level_nxt = fifo_level - LW'(1);
    end

    // Capture bookkeeping: pointers, level, full flag, drop counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_cap     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            fifo_full    <= 1'b0;
            overflow_cnt <= 8'd0;
        end else begin
            if (push_req) last_cap <= cap_word;
            if (push_ok)  wr_ptr   <= wr_ptr + 1'b1;
            if (pop)      rd_ptr   <= rd_ptr + 1'b1;
            if (push_req && fifo_full && overflow_cnt != 8'hFF)
                overflow_cnt <= overflow_cnt + 8'd1;
            fifo_level <= level_nxt;
            fifo_full  <= (level_nxt == LW'(FIFO_DEPTH));
        end
    end

    // FIFO storage, no reset needed: pointers define validity
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= cap_word;
    end

    // Character for the current index; hex digits come from the top nibble
    // of a left-shifting copy of the data word.
    always_comb begin
        next_char = 8'h0A;
        if (char_idx < 4'd8)
            next_char = hex_ascii(data_sh[31:28]);
`ifdef WB_TRACE_FLAGS_EN
        else if (char_idx == 4'd8)
            next_char = 8'h20;
        else if (char_idx == 4'd9)
            next_char = hex_ascii({3'b000, flags_q[4]});
        else if (char_idx == 4'd10)
            next_char = hex_ascii(flags_q[3:0]);
        else if (char_idx == 4'd11)
            next_char = 8'h0D;
`else
        else if (char_idx == 4'd8)
            next_char = 8'h0D;
`endif
    end

    // TX engine; uart_tx is registered so it follows the state by one cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            uart_tx  <= 1'b1;
            busy     <= 1'b0;
            cnt      <= '0;
            bit_idx  <= 3'd0;
            char_idx <= 4'd0;
            tx_char  <= 8'h00;
            data_sh  <= 32'h0;
`ifdef WB_TRACE_FLAGS_EN
            flags_q  <= 5'h0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    uart_tx <= 1'b1;
                    if (pop) begin
`ifdef WB_TRACE_FLAGS_EN
                        {flags_q, data_sh} <= mem[rd_ptr];
`else
                        data_sh <= mem[rd_ptr];
`endif
                        char_idx <= 4'd0;
                        busy     <= 1'b1;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    uart_tx <= 1'b1;
                    tx_char <= next_char;
                    if (char_idx < 4'd8) data_sh <= data_sh << 4;
                    cnt     <= '0;
                    state   <= S_START;
                end
                S_START: begin
                    uart_tx <= 1'b0;
                    if (bit_end) begin
                        cnt     <= '0;
                        bit_idx <= 3'd0;
                        state   <= S_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    uart_tx <= tx_char[bit_idx];
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) state   <= S_STOP;
                        else                 bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    uart_tx <= 1'b1;
                    if (bit_end) begin
                        cnt <= '0;
                        if (char_idx == 4'(NCH - 1)) begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            char_idx <= char_idx + 4'd1;
                            state    <= S_LOAD;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    uart_tx <= 1'b1;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
